// File: rtl/bid_round_seq.sv
// Auction round sequencer: accepts one round request, programs the auction
// through an 8-op command list, runs the round timer, then waits for the result.
module bid_round_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_key,
    input  logic [31:0] cfg_xval,
    input  logic [31:0] cfg_yval,
    input  logic [31:0] cfg_zval,
    input  logic [2:0]  cfg_mask,
    input  logic [31:0] cfg_timer,
    input  logic [31:0] cfg_cost,
    input  logic        abort,
    input  logic        ready,
    input  logic [1:0]  err,
    input  logic        roundOver,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    output logic        done,
    output logic [1:0]  status
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CHECK   = 3'd2,
        S_RUN     = 3'd3,
        S_WAIT_RO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOOP      = 4'd0;
    localparam logic [3:0] OP_UNLOCK    = 4'd1;
    localparam logic [3:0] OP_LOCK      = 4'd2;
    localparam logic [3:0] OP_LOADX     = 4'd3;
    localparam logic [3:0] OP_LOADY     = 4'd4;
    localparam logic [3:0] OP_LOADZ     = 4'd5;
    localparam logic [3:0] OP_SETMASK   = 4'd6;
    localparam logic [3:0] OP_SETTIMER  = 4'd7;
    localparam logic [3:0] OP_BIDCHARGE = 4'd8;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CFG_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    state_t      state;
    logic [2:0]  op_idx;
    logic [31:0] run_cnt;
    logic [3:0]  wd_cnt;

    logic [31:0] key_q;
    logic [31:0] xval_q;
    logic [31:0] yval_q;
    logic [31:0] zval_q;
    logic [2:0]  mask_q;
    logic [31:0] timer_q;
    logic [31:0] cost_q;

    logic [3:0]  cur_op;
    logic [31:0] cur_data;
    logic        chk_fail;
    logic        abort_hit;

    // Request handshake: a request transfers on the rising edge where
    // cfg_valid && cfg_ready; cfg_ready is high only in IDLE and never in reset.
    assign cfg_ready = (state == S_IDLE) && !reset;

    // Unlock may report "already unlocked" (2'b10) without failing the round.
    assign chk_fail  = (op_idx == 3'd0) ? ((err != 2'b00) && (err != 2'b10))
                                        : (err != 2'b00);

    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        cur_op   = OP_NOOP;
        cur_data = 32'd0;
        case (op_idx)
            3'd0: begin cur_op = OP_UNLOCK;    cur_data = key_q;            end
            3'd1: begin cur_op = OP_LOADX;     cur_data = xval_q;           end
            3'd2: begin cur_op = OP_LOADY;     cur_data = yval_q;           end
            3'd3: begin cur_op = OP_LOADZ;     cur_data = zval_q;           end
            3'd4: begin cur_op = OP_SETMASK;   cur_data = {29'd0, mask_q};  end
            3'd5: begin cur_op = OP_SETTIMER;  cur_data = timer_q;          end
            3'd6: begin cur_op = OP_BIDCHARGE; cur_data = cost_q;           end
            3'd7: begin cur_op = OP_LOCK;      cur_data = key_q;            end
            default: begin cur_op = OP_NOOP;   cur_data = 32'd0;            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_idx  <= 3'd0;
            run_cnt <= 32'd0;
            wd_cnt  <= 4'd0;
            key_q   <= 32'd0;
            xval_q  <= 32'd0;
            yval_q  <= 32'd0;
            zval_q  <= 32'd0;
            mask_q  <= 3'd0;
            timer_q <= 32'd0;
            cost_q  <= 32'd0;
            C_op    <= OP_NOOP;
            C_data  <= 32'd0;
            C_start <= 1'b0;
            done    <= 1'b0;
            status  <= ST_OK;
        end else if (abort_hit) begin
            state   <= S_DONE;
            status  <= ST_ABORTED;
            done    <= 1'b1;
            C_op    <= OP_NOOP;
            C_data  <= 32'd0;
            C_start <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (cfg_valid && cfg_ready) begin
                        key_q   <= cfg_key;
                        xval_q  <= cfg_xval;
                        yval_q  <= cfg_yval;
                        zval_q  <= cfg_zval;
                        mask_q  <= cfg_mask;
                        timer_q <= cfg_timer;
                        cost_q  <= cfg_cost;
                        op_idx  <= 3'd0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ready) begin
                        C_op   <= cur_op;
                        C_data <= cur_data;
                        state  <= S_CHECK;
                    end else begin
                        C_op   <= OP_NOOP;
                        C_data <= 32'd0;
                    end
                end
                S_CHECK: begin
                    C_op   <= OP_NOOP;
                    C_data <= 32'd0;
                    if (chk_fail) begin
                        status <= ST_CFG_ERR;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (op_idx == 3'd7) begin
                        // A zero-length round still runs for one cycle.
                        run_cnt <= (timer_q == 32'd0) ? 32'd1 : timer_q;
                        C_start <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        op_idx <= op_idx + 3'd1;
                        state  <= S_ISSUE;
                    end
                end
                S_RUN: begin
                    if (run_cnt <= 32'd1) begin
                        run_cnt <= 32'd0;
                        wd_cnt  <= 4'd0;
                        C_start <= 1'b0;
                        state   <= S_WAIT_RO;
                    end else begin
                        run_cnt <= run_cnt - 32'd1;
                    end
                end
                S_WAIT_RO: begin
                    if (roundOver) begin
                        status <= ST_OK;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (wd_cnt == 4'd15) begin
                        status <= ST_TIMEOUT;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    C_op    <= OP_NOOP;
                    C_data  <= 32'd0;
                    C_start <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bid_round_seq.sv
// Bench for bid_round_seq: scenario tasks plus an opcode scoreboard fed by
// the request driver and drained as the DUT issues commands.
module tb_bid_round_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_key, cfg_xval, cfg_yval, cfg_zval, cfg_timer, cfg_cost;
  logic [2:0]  cfg_mask;
  logic        abort, ready, roundOver;
  logic [1:0]  err;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start, done;
  logic [1:0]  status;

  logic [35:0] exp_q[$];
  logic [4:0]  trace_q[$];
  logic        trace_en = 1'b0;
  logic [35:0] sb_exp;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bid_round_seq dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_key(cfg_key), .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
    .abort(abort), .ready(ready), .err(err), .roundOver(roundOver),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .done(done), .status(status)
  );

  // Scoreboard drain and per-cycle trace, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (C_op !== 4'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_op: got op=%0d data=%h, expected no command", C_op, C_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({C_op, C_data} !== sb_exp) begin
            errors++;
            $display("FAIL sb_op: got op=%0d data=%h, expected op=%0d data=%h",
                     C_op, C_data, sb_exp[35:32], sb_exp[31:0]);
          end
        end
      end
      if (trace_en) trace_q.push_back({C_start, C_op});
    end
  end

  task automatic send_cfg(input logic [31:0] key, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [2:0] mask, input logic [31:0] timer,
                          input logic [31:0] cost, input int n_ops, input logic with_abort);
    logic [35:0] ops[8];
    bit seen;
    ops[0] = {4'd1, key};
    ops[1] = {4'd3, x};
    ops[2] = {4'd4, y};
    ops[3] = {4'd5, z};
    ops[4] = {4'd6, 29'd0, mask};
    ops[5] = {4'd7, timer};
    ops[6] = {4'd8, cost};
    ops[7] = {4'd2, key};
    for (int i = 0; i < n_ops; i++) exp_q.push_back(ops[i]);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (cfg_ready === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL cfg_ready_wait: cfg_ready=%b, expected 1 within 50 cycles", cfg_ready);
    end
    cfg_key = key; cfg_xval = x; cfg_yval = y; cfg_zval = z;
    cfg_mask = mask; cfg_timer = timer; cfg_cost = cost;
    cfg_valid = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    abort = 1'b0;
    trace_q.delete();
    trace_en = 1'b1;
  endtask

  // Runs to done; ro_delay<0 never raises roundOver.
  task automatic finish_round(input int ro_delay, output int hi, output int ftd,
                              output bit got, output logic [1:0] st);
    bit seen_hi;
    int k;
    seen_hi = 1'b0; k = -1; hi = 0; ftd = -1; got = 1'b0; st = 2'bxx;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (C_start === 1'b1) begin hi++; seen_hi = 1'b1; end
      else if (seen_hi) k++;
      if (done === 1'b1) begin
        got = 1'b1; st = status; ftd = k; roundOver = 1'b0;
      end else if (ro_delay >= 0 && k == ro_delay - 1) begin
        roundOver = 1'b1;
      end
    end
    roundOver = 1'b0;
    trace_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (C_op !== 4'd0) begin errors++; $display("FAIL reset_c_op: got %0d, expected 0", C_op); end
    checks++; if (C_data !== 32'd0) begin errors++; $display("FAIL reset_c_data: got %h, expected 0", C_data); end
    checks++; if (C_start !== 1'b0) begin errors++; $display("FAIL reset_c_start: got %b, expected 0", C_start); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b, expected 00", status); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b, expected 0", cfg_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, expected 1", cfg_ready); end
  endtask

  task automatic test_nominal();
    int hi, ftd;
    bit got;
    logic [1:0] st;
    logic [3:0] seq[17];
    seq = '{4'd0, 4'd1, 4'd0, 4'd3, 4'd0, 4'd4, 4'd0, 4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd2, 4'd0};
    send_cfg(32'h0F0F0F0F, 32'd100, 32'd200, 32'd300, 3'b111, 32'd5, 32'd1, 8, 1'b0);
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL nom_busy_ready: got %b, expected 0", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_xval = 32'hDEADBEEF;
    @(negedge clk);
    cfg_valid = 1'b0;
    finish_round(3, hi, ftd, got, st);
    checks++; if (!got) begin errors++; $display("FAIL nom_done: got no done, expected done within budget"); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL nom_status: got %b, expected 00", st); end
    checks++; if (hi != 5) begin errors++; $display("FAIL nom_cstart_len: got %0d, expected 5", hi); end
    checks++; if (ftd != 3) begin errors++; $display("FAIL nom_ro_latency: got %0d, expected 3", ftd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nom_sb_left: got %0d pending, expected 0", exp_q.size()); end
    checks++;
    if (trace_q.size() < 17) begin
      errors++; $display("FAIL nom_trace_len: got %0d, expected >= 17", trace_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (trace_q[i][3:0] !== seq[i]) begin
          errors++; $display("FAIL nom_op_seq[%0d]: got %0d, expected %0d", i, trace_q[i][3:0], seq[i]);
        end
      end
      checks++;
      if (trace_q[15][4] !== 1'b0 || trace_q[16][4] !== 1'b1) begin
        errors++; $display("FAIL nom_run_entry: got C_start %b,%b at cycles 15,16, expected 0,1", trace_q[15][4], trace_q[16][4]);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_width: got %b, expected 0", done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL nom_idle_ready: got %b, expected 1", cfg_ready); end
  endtask

  task automatic test_backpressure();
    int hi, ftd;
    bit got, found;
    logic [1:0] st;
    send_cfg(32'hA5A50001, 32'd11, 32'd22, 32'h12345678, 3'b101, 32'd3, 32'd7, 8, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      found = (C_op === 4'd4);
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_loady_seen: got no LoadY, expected LoadY"); end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (C_op !== 4'd0) begin errors++; $display("FAIL bp_stall[%0d]: got %0d, expected 0", i, C_op); end
    end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (C_op !== 4'd5) begin errors++; $display("FAIL bp_loadz_op: got %0d, expected 5", C_op); end
    checks++; if (C_data !== 32'h12345678) begin errors++; $display("FAIL bp_loadz_data: got %h, expected 12345678", C_data); end
    @(negedge clk);
    checks++; if (C_op !== 4'd0) begin errors++; $display("FAIL bp_loadz_width: got %0d, expected 0", C_op); end
    finish_round(2, hi, ftd, got, st);
    checks++; if (!got || st !== 2'b00) begin errors++; $display("FAIL bp_status: got done=%b status=%b, expected 1/00", got, st); end
    checks++; if (hi != 3) begin errors++; $display("FAIL bp_cstart_len: got %0d, expected 3", hi); end
  endtask

  task automatic test_timeout();
    int hi, ftd;
    bit got;
    logic [1:0] st;
    send_cfg(32'h11112222, 32'd1, 32'd2, 32'd3, 3'b010, 32'd4, 32'd9, 8, 1'b0);
    finish_round(-1, hi, ftd, got, st);
    checks++; if (!got || st !== 2'b10) begin errors++; $display("FAIL to_status: got done=%b status=%b, expected 1/10", got, st); end
    checks++; if (ftd != 16) begin errors++; $display("FAIL to_latency: got %0d, expected 16", ftd); end
    checks++; if (hi != 4) begin errors++; $display("FAIL to_cstart_len: got %0d, expected 4", hi); end
  endtask

  task automatic test_reset_in_run();
    int hi;
    bit saw_done;
    send_cfg(32'h33334444, 32'd5, 32'd6, 32'd7, 3'b001, 32'd10, 32'd2, 8, 1'b0);
    hi = 0;
    for (int c = 0; c < 40 && hi < 2; c++) begin
      @(negedge clk);
      if (C_start === 1'b1) hi++;
    end
    checks++; if (hi != 2) begin errors++; $display("FAIL rr_run_seen: got %0d run cycles, expected 2", hi); end
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL rr_status_hold: got %b, expected 10", status); end
    reset = 1'b1;
    #1;
    checks++; if (C_start !== 1'b0) begin errors++; $display("FAIL rr_c_start: got %b, expected 0", C_start); end
    checks++; if (C_op !== 4'd0 || C_data !== 32'd0) begin errors++; $display("FAIL rr_c_op: got %0d/%h, expected 0/0", C_op, C_data); end
    checks++; if (done !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL rr_done_status: got %b/%b, expected 0/00", done, status); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rr_cfg_ready: got %b, expected 0", cfg_ready); end
    trace_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rr_no_done: got done pulse, expected none"); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rr_ready_after: got %b, expected 1", cfg_ready); end
  endtask

  task automatic test_timer_zero();
    int hi, ftd;
    bit got;
    logic [1:0] st;
    send_cfg(32'h55556666, 32'd8, 32'd9, 32'd10, 3'b100, 32'd0, 32'd3, 8, 1'b0);
    finish_round(1, hi, ftd, got, st);
    checks++; if (!got || st !== 2'b00) begin errors++; $display("FAIL t0_status: got done=%b status=%b, expected 1/00", got, st); end
    checks++; if (hi != 1) begin errors++; $display("FAIL t0_cstart_len: got %0d, expected 1", hi); end
  endtask

  task automatic test_cfg_err();
    int n_ops[2];
    logic [1:0] unlock_err[2];
    logic [1:0] loady_err[2];
    bit got, cs_seen;
    logic [1:0] st;
    n_ops = '{3, 1};
    unlock_err = '{2'b10, 2'b01};
    loady_err = '{2'b11, 2'b00};
    for (int r = 0; r < 2; r++) begin
      send_cfg(32'h77778888 + r, 32'd100 + r, 32'd200 + r, 32'd300, 3'b011, 32'd6, 32'd4, n_ops[r], 1'b0);
      got = 1'b0; cs_seen = 1'b0; st = 2'bxx;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (C_start === 1'b1) cs_seen = 1'b1;
        if (done === 1'b1) begin got = 1'b1; st = status; end
        err = (C_op === 4'd1) ? unlock_err[r] : (C_op === 4'd4) ? loady_err[r] : 2'b00;
      end
      err = 2'b00;
      trace_en = 1'b0;
      checks++; if (!got || st !== 2'b01) begin errors++; $display("FAIL cerr_status[%0d]: got done=%b status=%b, expected 1/01", r, got, st); end
      checks++; if (cs_seen) begin errors++; $display("FAIL cerr_no_run[%0d]: got C_start high, expected never", r); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cerr_sb_left[%0d]: got %0d pending, expected 0", r, exp_q.size()); end
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    int hi, ftd;
    bit got;
    logic [1:0] st;
    send_cfg(32'h9999AAAA, 32'd1, 32'd1, 32'd1, 3'b111, 32'd10, 32'd1, 8, 1'b0);
    hi = 0;
    for (int c = 0; c < 40 && hi < 2; c++) begin
      @(negedge clk);
      if (C_start === 1'b1) hi++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (C_start !== 1'b0) begin errors++; $display("FAIL ab_c_start: got %b, expected 0", C_start); end
    checks++; if (done !== 1'b1 || status !== 2'b11) begin errors++; $display("FAIL ab_done: got done=%b status=%b, expected 1/11", done, status); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || status !== 2'b11) begin errors++; $display("FAIL ab_after: got done=%b status=%b, expected 0/11", done, status); end
    trace_en = 1'b0;
    send_cfg(32'hBBBBCCCC, 32'd4, 32'd5, 32'd6, 3'b110, 32'd2, 32'd8, 8, 1'b1);
    finish_round(3, hi, ftd, got, st);
    checks++; if (!got || st !== 2'b00) begin errors++; $display("FAIL ab_new_req: got done=%b status=%b, expected 1/00", got, st); end
    checks++; if (hi != 2) begin errors++; $display("FAIL ab_new_cstart: got %0d, expected 2", hi); end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0; ready = 1'b1; err = 2'b00; roundOver = 1'b0;
    cfg_key = 32'd0; cfg_xval = 32'd0; cfg_yval = 32'd0; cfg_zval = 32'd0;
    cfg_mask = 3'd0; cfg_timer = 32'd0; cfg_cost = 32'd0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_reset_in_run();
    test_timer_zero();
    test_cfg_err();
    test_abort();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_sb_left: got %0d pending, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
